// File: rtl/top_mod_pkg.sv
// top_mod_pkg
// Shared definitions for the 8-bit accumulator processor: datapath widths,
// memory depths, the opcode map and the controller state encoding.
// No ports; imported by acc_alu and top_mod.

package top_mod_pkg;

    localparam int ACC_W     = 8;
    localparam int PC_W      = 6;
    localparam int INSN_W    = 12;
    localparam int OP_W      = 4;
    localparam int RAM_AW    = 4;
    localparam int ROM_DEPTH = 1 << PC_W;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h2;
    localparam logic [OP_W-1:0] OP_STA  = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_JC   = 4'hB;
    localparam logic [OP_W-1:0] OP_RETI = 4'hC;
    localparam logic [OP_W-1:0] OP_NOT  = 4'hD;
    localparam logic [OP_W-1:0] OP_SHL  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } CtrlState;

endpackage

// File: rtl/acc_alu.sv
// acc_alu
// Combinational ALU for the accumulator processor.
// Ports:
//   op     in  4 : opcode of the executing instruction
//   a      in  8 : accumulator value
//   b      in  8 : memory operand or immediate
//   cin    in  1 : adder carry-in (1 for SUB, which is a + ~b + 1)
//   result out 8 : value to be written to the accumulator
//   cout   out 1 : adder carry-out, or the bit shifted out by SHL
//   zero   out 1 : result is all zeros
//   ovf    out 1 : two's-complement overflow of ADD/ADDI/SUB

module acc_alu
    import top_mod_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             cin,
    output logic [ACC_W-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    logic [ACC_W-1:0] addend;
    logic [ACC_W:0]   sum;

    // One shared 9-bit adder serves ADD, ADDI and SUB; SUB inverts the
    // operand and relies on cin for the +1, so a carry-out means "no borrow".
    // Overflow is judged on the operand actually fed to the adder.
    always_comb begin
        addend = (op == OP_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, addend} + (ACC_W+1)'(cin);
        result = a;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_ADDI, OP_SUB: begin
                result = sum[ACC_W-1:0];
                cout   = sum[ACC_W];
                ovf    = (a[ACC_W-1] == addend[ACC_W-1]) &&
                         (sum[ACC_W-1] != a[ACC_W-1]);
            end
            OP_LDI, OP_LDA: result = b;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_NOT:         result = ~a;
            OP_SHL: begin
                result = {a[ACC_W-2:0], 1'b0};
                cout   = a[ACC_W-1];
            end
            default:        result = a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/top_mod.sv
// top_mod
// 8-bit accumulator processor: 64x12 program ROM, 16x8 data RAM, a
// FETCH/DECODE/EXECUTE controller with a HALTED state, and a single
// vectored interrupt with one level of saved PC and flags.
// Parameters:
//   PROG_FILE  : name of the program image; the ROM array is loaded by the harness
//   INT_VECTOR : ROM address of the interrupt service routine
// Ports:
//   clk             in  1 : rising-edge clock
//   StartEverything in  1 : synchronous active-high reset / start
//   interrupt       in  1 : active-high interrupt request
//   ACCout          out 8 : accumulator
//   coutRegout      out 1 : carry flag
//   zeroRegout      out 1 : zero flag
//   overflowRegout  out 1 : signed-overflow flag
//   StageComplete   out 1 : high during the EXECUTE cycle of each instruction

module top_mod
    import top_mod_pkg::*;
#(
    parameter string           PROG_FILE  = "program.hex",
    parameter logic [PC_W-1:0] INT_VECTOR = 6'h30
) (
    input  logic             clk,
    input  logic             StartEverything,
    input  logic             interrupt,
    output logic [ACC_W-1:0] ACCout,
    output logic             coutRegout,
    output logic             zeroRegout,
    output logic             overflowRegout,
    output logic             StageComplete
);

    logic [INSN_W-1:0] rom [ROM_DEPTH];
    logic [ACC_W-1:0]  ram [RAM_DEPTH];

    CtrlState          state;
    CtrlState          nextState;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   nextPc;
    logic [PC_W-1:0]   epc;
    logic [INSN_W-1:0] ir;
    logic [ACC_W-1:0]  memData;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  nextAcc;
    logic              carryFlag;
    logic              zeroFlag;
    logic              ovfFlag;
    logic              nextCarry;
    logic              nextZero;
    logic              nextOvf;
    logic              savedCarry;
    logic              savedZero;
    logic              savedOvf;
    logic              pend;
    logic              ie;
    logic              takeInt;
    logic              doReti;
    logic              ramWe;
    logic [OP_W-1:0]   op;
    logic [ACC_W-1:0]  opnd;
    logic [ACC_W-1:0]  aluB;
    logic [ACC_W-1:0]  aluResult;
    logic              aluCout;
    logic              aluZero;
    logic              aluOvf;

    assign op   = ir[INSN_W-1:ACC_W];
    assign opnd = ir[ACC_W-1:0];
    assign aluB = ((op == OP_LDI) || (op == OP_ADDI)) ? opnd : memData;

    acc_alu uAlu (
        .op     (op),
        .a      (acc),
        .b      (aluB),
        .cin    (op == OP_SUB),
        .result (aluResult),
        .cout   (aluCout),
        .zero   (aluZero),
        .ovf    (aluOvf)
    );

    // Controller next-state and the architectural updates of the executing
    // instruction. nextPc already includes any jump or RETI redirect, which
    // is exactly what an interrupt taken at the end of EXECUTE must save.
    // In HALTED the PC already points past the HALT, so an interrupt taken
    // there returns to HALT+1.
    always_comb begin
        nextState = state;
        nextPc    = pc;
        nextAcc   = acc;
        nextCarry = carryFlag;
        nextZero  = zeroFlag;
        nextOvf   = ovfFlag;
        ramWe     = 1'b0;
        doReti    = 1'b0;
        takeInt   = 1'b0;
        case (state)
            FETCH: begin
                nextPc    = pc + PC_W'(1);
                nextState = DECODE;
            end
            DECODE: begin
                nextState = EXECUTE;
            end
            EXECUTE: begin
                nextState = FETCH;
                case (op)
                    OP_LDI, OP_LDA, OP_AND, OP_OR, OP_NOT: begin
                        nextAcc  = aluResult;
                        nextZero = aluZero;
                    end
                    OP_SHL: begin
                        nextAcc   = aluResult;
                        nextZero  = aluZero;
                        nextCarry = aluCout;
                    end
                    OP_ADD, OP_ADDI, OP_SUB: begin
                        nextAcc   = aluResult;
                        nextZero  = aluZero;
                        nextCarry = aluCout;
                        nextOvf   = aluOvf;
                    end
                    OP_STA: ramWe = 1'b1;
                    OP_JMP: nextPc = opnd[PC_W-1:0];
                    OP_JZ: begin
                        if (zeroFlag) begin
                            nextPc = opnd[PC_W-1:0];
                        end
                    end
                    OP_JC: begin
                        if (carryFlag) begin
                            nextPc = opnd[PC_W-1:0];
                        end
                    end
                    OP_RETI: begin
                        nextPc    = epc;
                        nextCarry = savedCarry;
                        nextZero  = savedZero;
                        nextOvf   = savedOvf;
                        doReti    = 1'b1;
                    end
                    OP_HALT: nextState = HALTED;
                    default: ;
                endcase
                if (pend && ie) begin
                    takeInt   = 1'b1;
                    nextState = FETCH;
                end
            end
            HALTED: begin
                if (pend && ie) begin
                    takeInt   = 1'b1;
                    nextState = FETCH;
                end
            end
            default: nextState = FETCH;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (StartEverything) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Architectural registers and interrupt bookkeeping. On interrupt entry
    // the request that caused it is consumed, so a request still asserted on
    // the entry edge does not cause a second service; a request arriving on
    // a later edge while ie is clear stays pending until after RETI.
    always_ff @(posedge clk) begin
        if (StartEverything) begin
            pc         <= '0;
            acc        <= '0;
            carryFlag  <= 1'b0;
            zeroFlag   <= 1'b0;
            ovfFlag    <= 1'b0;
            pend       <= 1'b0;
            ie         <= 1'b1;
            epc        <= '0;
            savedCarry <= 1'b0;
            savedZero  <= 1'b0;
            savedOvf   <= 1'b0;
        end else begin
            acc       <= nextAcc;
            carryFlag <= nextCarry;
            zeroFlag  <= nextZero;
            ovfFlag   <= nextOvf;
            if (takeInt) begin
                pc         <= INT_VECTOR;
                epc        <= nextPc;
                savedCarry <= nextCarry;
                savedZero  <= nextZero;
                savedOvf   <= nextOvf;
                ie         <= 1'b0;
                pend       <= 1'b0;
            end else begin
                pc <= nextPc;
                if (doReti) begin
                    ie <= 1'b1;
                end
                if (interrupt) begin
                    pend <= 1'b1;
                end
            end
        end
    end

    // Memory ports: instruction latch in FETCH, operand read in DECODE and
    // the STA write at the end of EXECUTE. The write is blocked by reset so
    // an aborted STA leaves the RAM untouched; RAM is otherwise never cleared.
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            ir <= rom[pc];
        end
        if (state == DECODE) begin
            memData <= ram[opnd[RAM_AW-1:0]];
        end
        if (ramWe && !StartEverything) begin
            ram[opnd[RAM_AW-1:0]] <= acc;
        end
    end

    assign ACCout         = acc;
    assign coutRegout     = carryFlag;
    assign zeroRegout     = zeroFlag;
    assign overflowRegout = ovfFlag;
    assign StageComplete  = (state == EXECUTE);

endmodule

// File: tb/tb_top_mod.sv
// tb_top_mod
// Directed testbench for top_mod. Programs are written straight into the
// DUT ROM while reset is held; inputs change and outputs are sampled on the
// falling clock edge. Cycle numbers in comments count falling edges after
// StartEverything is released; instruction k completes on edge 3k+3.

module tb_top_mod;

    logic       clk = 1'b0;
    logic       StartEverything;
    logic       interrupt;
    logic [7:0] ACCout;
    logic       coutRegout;
    logic       zeroRegout;
    logic       overflowRegout;
    logic       StageComplete;

    int vectorCount = 0;
    int missCount   = 0;
    int scCount     = 0;
    int quietHigh;

    top_mod #(
        .PROG_FILE  (""),
        .INT_VECTOR (6'h30)
    ) dut (
        .clk             (clk),
        .StartEverything (StartEverything),
        .interrupt       (interrupt),
        .ACCout          (ACCout),
        .coutRegout      (coutRegout),
        .zeroRegout      (zeroRegout),
        .overflowRegout  (overflowRegout),
        .StageComplete   (StageComplete)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Count completion pulses for whole-program checks.
    always @(negedge clk) begin
        if (StageComplete === 1'b1) begin
            scCount++;
        end
    end

    // Guard against a hung simulation.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: still running at %0t, limit 50000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Fill the ROM with HALT and place the ISR (LDI AA; RETI) at 0x30.
    task automatic clearRom();
        for (int i = 0; i < 64; i++) begin
            dut.rom[i] = 12'hF00;
        end
        dut.rom[6'h30] = 12'h1AA;
        dut.rom[6'h31] = 12'hC00;
    endtask

    // Hold reset for a number of cycles, then release it and restart counting.
    task automatic applyStimulus(input int holdCycles);
        StartEverything = 1'b1;
        repeat (holdCycles) @(negedge clk);
        StartEverything = 1'b0;
        scCount = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkFlags(input string tag, input logic c, input logic z, input logic v);
        checkOutput({tag, "_cout"}, 16'(coutRegout), 16'(c));
        checkOutput({tag, "_zero"}, 16'(zeroRegout), 16'(z));
        checkOutput({tag, "_ovf"},  16'(overflowRegout), 16'(v));
    endtask

    initial begin
        StartEverything = 1'b1;
        interrupt       = 1'b0;
        @(negedge clk);

        // Reset values, first-pulse timing and ADDI flag corners.
        $display("[TB] reset and ADDI flags");
        clearRom();
        dut.rom[0] = 12'h17F;
        dut.rom[1] = 12'h801;
        dut.rom[2] = 12'h1FF;
        dut.rom[3] = 12'h801;
        waitCycles(2);
        checkOutput("rstAcc", 16'(ACCout), 16'h00);
        checkFlags("rst", 1'b0, 1'b0, 1'b0);
        checkOutput("rstStage", 16'(StageComplete), 16'h0);
        StartEverything = 1'b0;
        scCount = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pulse%0d", i), 16'(StageComplete), 16'((i % 3) == 2));
            if (i == 6) begin
                checkOutput("addi7F01", 16'(ACCout), 16'h80);
                checkFlags("addi7F01", 1'b0, 1'b0, 1'b1);
            end
        end
        waitCycles(5);
        checkOutput("addiFF01", 16'(ACCout), 16'h00);
        checkFlags("addiFF01", 1'b1, 1'b1, 1'b0);
        quietHigh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && StageComplete) quietHigh++;
        end
        checkOutput("haltQuiet1", 16'(quietHigh), 16'd0);
        checkOutput("pulses1", 16'(scCount), 16'd5);

        // SUB borrow and equal-operand cases through RAM.
        $display("[TB] SUB through RAM");
        clearRom();
        dut.rom[0] = 12'h105;
        dut.rom[1] = 12'h303;
        dut.rom[2] = 12'h103;
        dut.rom[3] = 12'h503;
        dut.rom[4] = 12'h105;
        dut.rom[5] = 12'h503;
        applyStimulus(2);
        waitCycles(12);
        checkOutput("sub0305", 16'(ACCout), 16'hFE);
        checkFlags("sub0305", 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        checkOutput("sub0505", 16'(ACCout), 16'h00);
        checkFlags("sub0505", 1'b1, 1'b1, 1'b0);

        // Countdown loop: LDI 03; ADDI FF; JZ 5; JMP 1; HALT (HALT also at 5).
        $display("[TB] countdown loop");
        clearRom();
        dut.rom[0] = 12'h103;
        dut.rom[1] = 12'h8FF;
        dut.rom[2] = 12'hA05;
        dut.rom[3] = 12'h901;
        applyStimulus(2);
        waitCycles(29);
        checkOutput("loopHaltPulse", 16'(StageComplete), 16'h1);
        waitCycles(1);
        checkOutput("loopAcc", 16'(ACCout), 16'h00);
        checkFlags("loop", 1'b1, 1'b1, 1'b0);
        quietHigh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (StageComplete) quietHigh++;
        end
        checkOutput("haltQuiet3", 16'(quietHigh), 16'd0);
        checkOutput("pulses3", 16'(scCount), 16'd10);

        // Same loop, 30 ns interrupt over edges 24..26: entry at the end of
        // the taken JZ (edge 27), EPC=5, saved flags C=1 Z=1.
        $display("[TB] interrupt during loop");
        applyStimulus(2);
        waitCycles(23);
        interrupt = 1'b1;
        waitCycles(3);
        interrupt = 1'b0;
        waitCycles(1);
        checkOutput("intBeforeIsr", 16'(ACCout), 16'h00);
        waitCycles(3);
        checkOutput("isrLdiAcc", 16'(ACCout), 16'hAA);
        checkOutput("isrLdiZero", 16'(zeroRegout), 16'h0);
        waitCycles(3);
        checkOutput("retiAcc", 16'(ACCout), 16'hAA);
        checkFlags("reti", 1'b1, 1'b1, 1'b0);
        waitCycles(12);
        checkOutput("pulses4", 16'(scCount), 16'd12);
        checkOutput("intEndAcc", 16'(ACCout), 16'hAA);

        // Interrupt while HALTED, plus a second request inside the ISR.
        $display("[TB] halted interrupt and nested request");
        clearRom();
        dut.rom[0] = 12'h111;
        dut.rom[2] = 12'h122;
        applyStimulus(2);
        waitCycles(9);
        checkOutput("haltedAcc", 16'(ACCout), 16'h11);
        checkOutput("haltedStage", 16'(StageComplete), 16'h0);
        waitCycles(1);
        interrupt = 1'b1;
        waitCycles(1);
        interrupt = 1'b0;
        waitCycles(3);
        interrupt = 1'b1;
        waitCycles(1);
        interrupt = 1'b0;
        checkOutput("isr1Acc", 16'(ACCout), 16'hAA);
        waitCycles(6);
        checkOutput("resumeAcc", 16'(ACCout), 16'h22);
        waitCycles(3);
        checkOutput("isr2Acc", 16'(ACCout), 16'hAA);
        waitCycles(16);
        checkOutput("pulses5", 16'(scCount), 16'd8);
        checkOutput("halt5Stage", 16'(StageComplete), 16'h0);

        // Reset aborts an STA in EXECUTE; an interrupt during reset is dropped.
        $display("[TB] reset abort");
        clearRom();
        dut.rom[0] = 12'h111;
        dut.rom[1] = 12'h302;
        applyStimulus(2);
        waitCycles(9);
        clearRom();
        dut.rom[0] = 12'h15A;
        dut.rom[1] = 12'h302;
        applyStimulus(2);
        waitCycles(5);
        checkOutput("abortInExec", 16'(StageComplete), 16'h1);
        StartEverything = 1'b1;
        interrupt       = 1'b1;
        waitCycles(2);
        clearRom();
        dut.rom[0] = 12'h202;
        interrupt = 1'b0;
        applyStimulus(1);
        waitCycles(3);
        checkOutput("ramKept", 16'(ACCout), 16'h11);
        waitCycles(12);
        checkOutput("intDropped", 16'(scCount), 16'd2);
        checkOutput("intDroppedAcc", 16'(ACCout), 16'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
